// File: rtl/cpu_fetch_if.sv
// Instruction memory read bus between cpu_fetch (master) and instruction memory (slave).
//
// Handshake: the master raises stb with a word-aligned address. It holds both stable until
// the slave returns ack for one cycle with data. Each ack completes exactly one request.
// There is no separate ready; a held stb is the request.
interface cpu_fetch_if;
    logic [31:0] address;
    logic        stb;
    logic        ack;
    logic [31:0] data;

    modport master (output address, output stb, input ack, input data);
    modport slave  (input address, input stb, output ack, output data);
endinterface

// File: rtl/cpu_fetch.sv
// cpu_fetch: instruction fetch and align unit feeding cpu_decode.
// Reads big-endian 32-bit words into a halfword queue, assembles 16-bit short and 48-bit
// long moxie instructions, and issues at most one per cycle. Handles flush and stall.
// Optional macro CPU_FETCH_STATS_EN adds bubble_count_o (saturating idle-issue counter).
module cpu_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h00001000,
    parameter int          QUEUE_HW     = 6
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    cpu_fetch_if.master imem,
    output logic [15:0] opcode_o,
    output logic [31:0] operand_o,
    output logic        valid_o,
    output logic [31:0] PC_o,
`ifdef CPU_FETCH_STATS_EN
    output logic [31:0] bubble_count_o,
`endif
    output logic [1:0]  fetch_state
);

    localparam int            CW         = $clog2(QUEUE_HW + 1);
    localparam logic [CW-1:0] REQ_LIMIT  = CW'(QUEUE_HW - 2);
    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] TWO        = CW'(2);
    localparam logic [CW-1:0] THREE      = CW'(3);
    localparam logic [31:0]   RESET_WORD = {RESET_VECTOR[31:2], 2'b00};
    localparam logic [31:0]   RESET_HALF = {RESET_VECTOR[31:1], 1'b0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [15:0]   q      [QUEUE_HW];
    logic [15:0]   q_next [QUEUE_HW];
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] pop_n;
    logic [CW-1:0] push_n;
    logic [31:0]   head_pc;
    logic [31:0]   redirect_addr;
    logic          drop_upper;
    logic          head_long;
    logic          head_ready;
    logic          do_issue;
    logic          accept;
    logic [31:0]   flush_word;
    logic [31:0]   flush_half;
    logic          unused_flush_lsb;

    // Opcodes whose high byte marks a 3-halfword (long) instruction.
    function automatic logic is_long(input logic [7:0] op);
        case (op)
            8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
            8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39: is_long = 1'b1;
            default: is_long = 1'b0;
        endcase
    endfunction

    assign flush_word       = {flush_pc_i[31:2], 2'b00};
    assign flush_half       = {flush_pc_i[31:1], 1'b0};
    assign unused_flush_lsb = flush_pc_i[0];
    assign fetch_state      = state;

    // Decide how many halfwords leave (issue) and enter (accepted ack) the queue this cycle.
    always_comb begin
        head_long  = is_long(q[0][15:8]);
        head_ready = (count != '0) && (!head_long || count >= THREE);
        do_issue   = !flush_i && !stall_i && head_ready;
        accept     = (state == REQ) && imem.ack && !flush_i;
        pop_n      = '0;
        if (do_issue) pop_n = head_long ? THREE : ONE;
        push_n     = '0;
        if (accept) push_n = drop_upper ? ONE : TWO;
        count_next = count - pop_n + push_n;
    end

    // Next queue image: shift out popped halfwords, then append accepted data behind the survivors.
    always_comb begin
        int base;
        base = int'(count) - int'(pop_n);
        for (int i = 0; i < QUEUE_HW; i++) begin
            q_next[i] = 16'h0;
            for (int j = 0; j < QUEUE_HW; j++) begin
                if (j == i + int'(pop_n)) q_next[i] = q[j];
            end
            if (accept && i == base) q_next[i] = drop_upper ? imem.data[15:0] : imem.data[31:16];
            if (accept && !drop_upper && i == base + 1) q_next[i] = imem.data[15:0];
        end
    end

    // Fetch FSM: request words while at least two slots are free; drain a request cut off by a flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            imem.stb      <= 1'b0;
            imem.address  <= RESET_WORD;
            redirect_addr <= RESET_WORD;
            drop_upper    <= RESET_VECTOR[1];
        end else begin
            if (flush_i) begin
                redirect_addr <= flush_word;
                drop_upper    <= flush_pc_i[1];
            end
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        imem.address <= flush_word;
                    end else if (count <= REQ_LIMIT) begin
                        state    <= REQ;
                        imem.stb <= 1'b1;
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        if (imem.ack) begin
                            state        <= IDLE;
                            imem.stb     <= 1'b0;
                            imem.address <= flush_word;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (imem.ack) begin
                        drop_upper   <= 1'b0;
                        imem.address <= imem.address + 32'd4;
                        if (count_next > REQ_LIMIT) begin
                            state    <= IDLE;
                            imem.stb <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (imem.ack) begin
                        state        <= IDLE;
                        imem.stb     <= 1'b0;
                        imem.address <= flush_i ? flush_word : redirect_addr;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem.stb <= 1'b0;
                end
            endcase
        end
    end

    // Queue update and registered issue to decode; flush clears, stall holds outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count     <= '0;
            for (int i = 0; i < QUEUE_HW; i++) q[i] <= 16'h0;
            valid_o   <= 1'b0;
            opcode_o  <= 16'h0;
            operand_o <= 32'h0;
            PC_o      <= 32'h0;
            head_pc   <= RESET_HALF;
        end else if (flush_i) begin
            count   <= '0;
            valid_o <= 1'b0;
            head_pc <= flush_half;
        end else begin
            count <= count_next;
            for (int i = 0; i < QUEUE_HW; i++) q[i] <= q_next[i];
            if (!stall_i) begin
                valid_o <= head_ready;
                if (head_ready) begin
                    opcode_o  <= q[0];
                    operand_o <= head_long ? {q[1], q[2]} : 32'h0;
                    PC_o      <= head_pc;
                    head_pc   <= head_pc + (head_long ? 32'd6 : 32'd2);
                end
            end
        end
    end

`ifdef CPU_FETCH_STATS_EN
    // Count unstalled cycles where nothing complete sits at the queue head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_count_o <= 32'h0;
        end else if (flush_i) begin
            bubble_count_o <= 32'h0;
        end else if (!stall_i && !head_ready && bubble_count_o != 32'hFFFFFFFF) begin
            bubble_count_o <= bubble_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_fetch.sv
// Testbench for cpu_fetch: directed scenarios plus randomized stall/flush/ack-delay traffic.
// Checked against a program-order model that decodes the bench memory directly.
module tb_cpu_fetch;
    localparam logic [31:0] RV = 32'h00001000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic [15:0] opcode;
    logic [31:0] operand;
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  fetch_state;
`ifdef CPU_FETCH_STATS_EN
    logic [31:0] bubble_count;
`endif

    int total = 0;
    int bad   = 0;

    cpu_fetch_if bus ();

    cpu_fetch #(.RESET_VECTOR(RV), .QUEUE_HW(6)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stall_i        (stall),
        .flush_i        (flush),
        .flush_pc_i     (flush_pc),
        .imem           (bus),
        .opcode_o       (opcode),
        .operand_o      (operand),
        .valid_o        (valid),
        .PC_o           (pc),
`ifdef CPU_FETCH_STATS_EN
        .bubble_count_o (bubble_count),
`endif
        .fetch_state    (fetch_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // instruction memory: 16 KB image, aliased over the whole address space, ack after ack_delay cycles
    logic [31:0] mem [4096];
    int ack_delay = 1;
    int wait_cnt  = 0;

    always @(posedge clk) begin
        bus.ack <= 1'b0;
        if (rst) begin
            wait_cnt <= 0;
        end else if (bus.stb && !bus.ack) begin
            if (wait_cnt + 1 >= ack_delay) begin
                bus.ack  <= 1'b1;
                bus.data <= mem[bus.address[13:2]];
                wait_cnt <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    // reference model: walk the memory image in program order
    logic [7:0] long_ops [17] = '{8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
                                  8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39};
    logic [79:0] exp_q [$];

    function automatic logic is_long_ref(input logic [15:0] op);
        for (int k = 0; k < 17; k++) if (long_ops[k] == op[15:8]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[13:2]];
        return a[1] ? w[15:0] : w[31:16];
    endfunction

    function automatic void fill_exp(input logic [31:0] start);
        logic [31:0] a;
        logic [15:0] op;
        logic [31:0] opd;
        exp_q.delete();
        a = {start[31:1], 1'b0};
        for (int n = 0; n < 300; n++) begin
            op  = hw_at(a);
            opd = is_long_ref(op) ? {hw_at(a + 32'd2), hw_at(a + 32'd4)} : 32'h0;
            exp_q.push_back({a, op, opd});
            a = a + (is_long_ref(op) ? 32'd6 : 32'd2);
        end
    endfunction

    // scoreboard: at each negedge judge the outputs produced by the previous cycle's inputs
    logic        p_rst   = 1'b1;
    logic        p_stall = 1'b0;
    logic        p_flush = 1'b0;
    logic [31:0] p_fpc   = 32'h0;
    logic [80:0] held    = '0;
    logic [79:0] e;

    always @(negedge clk) begin
        if (rst) begin
            fill_exp(RV);
        end else if (p_rst) begin
            // outputs still show the reset values from the last edge
        end else if (p_flush) begin
            total++;
            if (valid !== 1'b0) begin
                bad++;
                $display("FAIL sb_flush_valid got=%b exp=0", valid);
            end
            fill_exp(p_fpc);
        end else if (p_stall) begin
            total++;
            if ({valid, pc, opcode, operand} !== held) begin
                bad++;
                $display("FAIL sb_stall_hold got=%h exp=%h", {valid, pc, opcode, operand}, held);
            end
        end else if (valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_issue got=pc %h exp=none", pc);
            end else begin
                e = exp_q.pop_front();
                if ({pc, opcode, operand} !== e) begin
                    bad++;
                    $display("FAIL sb_issue got=pc %h op %h opd %h exp=pc %h op %h opd %h",
                             pc, opcode, operand, e[79:48], e[47:32], e[31:0]);
                end
            end
        end
        held    = {valid, pc, opcode, operand};
        p_rst   = rst;
        p_stall = stall;
        p_flush = flush;
        p_fpc   = flush_pc;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_issue(input int budget, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            tick();
            n++;
            if (valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic fill_short(input int first, input int words);
        for (int i = 0; i < words; i++) mem[first + i] = {8'h0E, 8'(i), 8'h10, 8'(i)};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++; if (valid !== 1'b0)           begin bad++; $display("FAIL rst_valid got=%b exp=0", valid); end
        total++; if (opcode !== 16'h0)         begin bad++; $display("FAIL rst_opcode got=%h exp=0", opcode); end
        total++; if (operand !== 32'h0)        begin bad++; $display("FAIL rst_operand got=%h exp=0", operand); end
        total++; if (pc !== 32'h0)             begin bad++; $display("FAIL rst_pc got=%h exp=0", pc); end
        total++; if (bus.stb !== 1'b0)         begin bad++; $display("FAIL rst_stb got=%b exp=0", bus.stb); end
        total++; if (bus.address !== RV)       begin bad++; $display("FAIL rst_address got=%h exp=%h", bus.address, RV); end
        total++; if (fetch_state !== 2'd0)     begin bad++; $display("FAIL rst_state got=%0d exp=0", fetch_state); end
        tick();
    endtask

    task automatic test_basic();
        fill_short(1024, 16);
        mem[1024] = 32'h0212_0E34;
        do_reset();
        repeat (3) tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", valid); end
        tick();
        total++;
        if ({valid, opcode, operand, pc} !== {1'b1, 16'h0212, 32'h0, 32'h1000}) begin
            bad++; $display("FAIL basic_first got=%b %h %h %h exp=1 0212 0 1000", valid, opcode, operand, pc);
        end
        tick();
        total++;
        if ({valid, opcode, pc} !== {1'b1, 16'h0E34, 32'h1002}) begin
            bad++; $display("FAIL basic_second got=%b %h %h exp=1 0e34 1002", valid, opcode, pc);
        end
        repeat (6) tick();
    endtask

    task automatic test_long_split();
        bit ok;
        fill_short(1024, 16);
        mem[1024] = 32'h0000_0110;
        mem[1025] = 32'hDEAD_BEEF;
        do_reset();
        wait_issue(20, ok);
        total++; if (!ok || pc !== 32'h1000 || opcode !== 16'h0000) begin
            bad++; $display("FAIL long_nop got=%b pc %h op %h exp=pc 1000 op 0000", ok, pc, opcode); end
        wait_issue(20, ok);
        total++; if (!ok || pc !== 32'h1002 || opcode !== 16'h0110 || operand !== 32'hDEADBEEF) begin
            bad++; $display("FAIL long_ldi got=%b pc %h op %h opd %h exp=pc 1002 op 0110 opd deadbeef", ok, pc, opcode, operand); end
        wait_issue(20, ok);
        total++; if (!ok || pc !== 32'h1008) begin
            bad++; $display("FAIL long_next_pc got=%b pc %h exp=1008", ok, pc); end
        repeat (4) tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int streak;
        fill_short(1024, 64);
        do_reset();
        wait_issue(20, ok);
        streak = 0;
        repeat (20) begin
            tick();
            if (valid === 1'b1) streak++;
        end
        total++; if (!ok || streak != 20) begin
            bad++; $display("FAIL b2b_throughput got=%0d exp=20", streak); end
    endtask

    task automatic test_stall();
        bit ok;
        int held_ok;
        fill_short(1024, 16);
        mem[1024] = 32'h0212_0E34;
        mem[1025] = 32'h0E35_0E36;
        do_reset();
        wait_issue(20, ok);
        total++; if (!ok || pc !== 32'h1000) begin bad++; $display("FAIL stall_first got=pc %h exp=1000", pc); end
        stall   = 1'b1;
        held_ok = 0;
        repeat (4) begin
            tick();
            if (valid === 1'b1 && pc === 32'h1000 && opcode === 16'h0212) held_ok++;
        end
        total++; if (held_ok != 4) begin bad++; $display("FAIL stall_hold got=%0d exp=4", held_ok); end
        stall = 1'b0;
        tick();
        total++; if (valid !== 1'b1 || pc !== 32'h1002 || opcode !== 16'h0E34) begin
            bad++; $display("FAIL stall_release got=%b pc %h op %h exp=1 1002 0e34", valid, pc, opcode); end
        tick();
        total++; if (valid !== 1'b1 || pc !== 32'h1004 || opcode !== 16'h0E35) begin
            bad++; $display("FAIL stall_after got=%b pc %h op %h exp=1 1004 0e35", valid, pc, opcode); end
        repeat (4) tick();
    endtask

    task automatic test_flush_outstanding();
        bit ok;
        int n;
        fill_short(1024, 16);
        fill_short(2048, 16);
        mem[2048] = 32'h0123_0E34;
        ack_delay = 3;
        do_reset();
        n = 0;
        while (bus.stb !== 1'b1 && n < 10) begin tick(); n++; end
        total++; if (bus.stb !== 1'b1) begin bad++; $display("FAIL fo_stb got=%b exp=1", bus.stb); end
        flush    = 1'b1;
        flush_pc = 32'h0000_2002;
        tick();
        flush = 1'b0;
        wait_issue(40, ok);
        total++; if (!ok || pc !== 32'h2002 || opcode !== 16'h0E34 || operand !== 32'h0) begin
            bad++; $display("FAIL fo_first got=%b pc %h op %h opd %h exp=pc 2002 op 0e34 opd 0", ok, pc, opcode, operand); end
        repeat (10) tick();
        ack_delay = 1;
    endtask

    task automatic test_flush_stall();
        bit ok;
        fill_short(1024, 16);
        fill_short(2048, 16);
        do_reset();
        wait_issue(20, ok);
        stall    = 1'b1;
        flush    = 1'b1;
        flush_pc = 32'h0000_2000;
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL fs_valid got=%b exp=0", valid); end
        stall = 1'b0;
        flush = 1'b0;
        wait_issue(20, ok);
        total++; if (!ok || pc !== 32'h2000 || opcode !== mem[2048][31:16]) begin
            bad++; $display("FAIL fs_resume got=pc %h op %h exp=pc 2000 op %h", pc, opcode, mem[2048][31:16]); end
        repeat (4) tick();
    endtask

    task automatic test_queue_full();
        bit ok;
        fill_short(1024, 16);
        do_reset();
        stall = 1'b1;
        repeat (20) tick();
        total++; if (bus.stb !== 1'b0 || fetch_state !== 2'd0) begin
            bad++; $display("FAIL qfull_idle got=stb %b st %0d exp=stb 0 st 0", bus.stb, fetch_state); end
        stall = 1'b0;
        wait_issue(5, ok);
        total++; if (!ok || pc !== 32'h1000) begin bad++; $display("FAIL qfull_resume got=pc %h exp=1000", pc); end
        repeat (15) tick();
    endtask

    task automatic test_wrap();
        bit ok;
        mem[4095] = 32'h0E34_0E35;
        mem[0]    = 32'h0E36_0E37;
        do_reset();
        repeat (3) tick();
        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        wait_issue(20, ok);
        total++; if (!ok || pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_first got=pc %h exp=fffffffc", pc); end
        wait_issue(20, ok);
        wait_issue(20, ok);
        total++; if (!ok || pc !== 32'h0 || opcode !== 16'h0E36) begin
            bad++; $display("FAIL wrap_zero got=pc %h op %h exp=pc 0 op 0e36", pc, opcode); end
        repeat (4) tick();
    endtask

    task automatic test_random();
        int issues;
        logic ps;
        logic pf;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom();
        do_reset();
        issues = 0;
        ps = 1'b0;
        pf = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) ack_delay = $urandom_range(1, 4);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) flush_pc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
            else flush_pc = 32'($urandom_range(0, 16383));
            ps = stall;
            pf = flush;
            tick();
            if (!ps && !pf && valid === 1'b1) issues++;
        end
        stall = 1'b0;
        flush = 1'b0;
        ack_delay = 1;
        repeat (10) tick();
        total++; if (issues < 100) begin bad++; $display("FAIL rand_progress got=%0d exp=>=100", issues); end
    endtask

`ifdef CPU_FETCH_STATS_EN
    task automatic test_bubble();
        int exp_b;
        fill_short(1024, 16);
        ack_delay = 5;
        do_reset();
        exp_b = 0;
        repeat (40) begin
            tick();
            if (valid === 1'b0) exp_b++;
        end
        total++; if (bubble_count !== 32'(exp_b)) begin
            bad++; $display("FAIL bubble_count got=%0d exp=%0d", bubble_count, exp_b); end
        flush    = 1'b1;
        flush_pc = 32'h1000;
        tick();
        flush = 1'b0;
        total++; if (bubble_count !== 32'h0) begin
            bad++; $display("FAIL bubble_clear got=%0d exp=0", bubble_count); end
        ack_delay = 1;
        repeat (4) tick();
    endtask
`endif

    initial begin
        rst      = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        flush_pc = 32'h0;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom();
        test_reset();
        test_basic();
        test_long_split();
        test_back_to_back();
        test_stall();
        test_flush_outstanding();
        test_flush_stall();
        test_queue_full();
        test_wrap();
        test_random();
`ifdef CPU_FETCH_STATS_EN
        test_bubble();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
